// File: rtl/mem_dma_pkg.sv
// Shared types and default widths for the mem_dma copy/fill engine.
package mem_dma_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/mem_dma_if.sv
// Single-cycle block-RAM port: the DMA is the master (initiator), the memory is the slave.
interface mem_dma_if #(
   parameter int AW = 16,
   parameter int DW = 16
);

   logic [AW-1:0] mem_raddr;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;

   modport master (
      output mem_raddr,
      output mem_re,
      input  mem_rdata,
      output mem_waddr,
      output mem_wdata,
      output mem_we
   );

   modport slave (
      input  mem_raddr,
      input  mem_re,
      output mem_rdata,
      input  mem_waddr,
      input  mem_wdata,
      input  mem_we
   );

endinterface

// File: rtl/mem_dma_agen.sv
// Address counter: loads a base address and direction, then steps by +/-1 modulo 2^AW.
module mem_dma_agen
   import mem_dma_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          dec,
   input  logic          step,
   output logic [AW-1:0] addr
);

   logic dec_r;

   // Direction is captured with the base so it stays fixed for the whole command
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr  <= '0;
         dec_r <= 1'b0;
      end else if (load) begin
         addr  <= load_val;
         dec_r <= dec;
      end else if (step) begin
         addr  <= dec_r ? (addr - AW'(1)) : (addr + AW'(1));
      end
   end

endmodule

// File: rtl/mem_dma.sv
// Bus-master copy/fill engine: one word per clock, overlap-safe copy direction.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          fill,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] count,
   input  logic [DW-1:0] fill_value,
   output logic          busy,
   output logic          done,
   mem_dma_if.master     mem
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   logic [1:0]    state;
   logic          fill_r;
   logic          re_r;
   logic          we_p1;
   logic          busy_r;
   logic          done_r;
   logic [AW-1:0] rem;
   logic [AW-1:0] waddr_p1;
   logic [AW-1:0] raddr;
   logic [AW-1:0] wnext;
   logic [AW-1:0] rd_load_val;
   logic [AW-1:0] wr_load_val;
   logic [DW-1:0] fval_r;
   logic          accept;
   logic          desc;
   logic          last;
   logic          rd_step;
   logic          wr_step;

   assign accept  = (state == ST_IDLE) && start;
   assign desc    = dst > src;
   assign last    = (rem == AW'(1));
   assign rd_step = (state == ST_RUN) && !fill_r;
   assign wr_step = (state == ST_RUN);

   // First read/write addresses; fill pre-advances the write counter because
   // its first write address is issued straight from dst at the accept edge
   always_comb begin
      rd_load_val = src;
      wr_load_val = dst;
      if (fill) begin
         wr_load_val = dst + AW'(1);
      end else if (desc) begin
         rd_load_val = src + count - AW'(1);
         wr_load_val = dst + count - AW'(1);
      end
   end

   mem_dma_agen #(.AW(AW)) u_rd_agen (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (rd_load_val),
      .dec      (desc & ~fill),
      .step     (rd_step),
      .addr     (raddr)
   );

   mem_dma_agen #(.AW(AW)) u_wr_agen (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (wr_load_val),
      .dec      (desc & ~fill),
      .step     (wr_step),
      .addr     (wnext)
   );

   // Fill pattern is data only, so it is captured without reset
   always_ff @(posedge clk) begin
      if (accept) begin
         fval_r <= fill_value;
      end
   end

   // Control FSM plus the pending-write stage that trails each read by one cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         fill_r   <= 1'b0;
         rem      <= '0;
         re_r     <= 1'b0;
         we_p1    <= 1'b0;
         waddr_p1 <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  busy_r <= 1'b1;
                  fill_r <= fill;
                  rem    <= count;
                  if (count == '0) begin
                     done_r <= 1'b1;
                     state  <= ST_DONE;
                  end else if (fill) begin
                     we_p1    <= 1'b1;
                     waddr_p1 <= dst;
                     state    <= ST_RUN;
                  end else begin
                     re_r  <= 1'b1;
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               rem <= rem - AW'(1);
               if (fill_r) begin
                  if (last) begin
                     we_p1  <= 1'b0;
                     done_r <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     waddr_p1 <= wnext;
                  end
               end else begin
                  we_p1    <= 1'b1;
                  waddr_p1 <= wnext;
                  if (last) begin
                     re_r  <= 1'b0;
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               we_p1  <= 1'b0;
               done_r <= 1'b1;
               state  <= ST_DONE;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign mem.mem_re    = re_r;
   assign mem.mem_raddr = raddr;
   assign mem.mem_we    = we_p1;
   assign mem.mem_waddr = waddr_p1;
   assign mem.mem_wdata = we_p1 ? (fill_r ? fval_r : mem.mem_rdata) : '0;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma with a behavioural memmove/fill reference model.
module tb_mem_dma;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        fill = 1'b0;
   logic [15:0] src = '0;
   logic [15:0] dst = '0;
   logic [15:0] count = '0;
   logic [15:0] fill_value = '0;
   logic        busy;
   logic        done;

   mem_dma_if #(.AW(16), .DW(16)) m ();

   mem_dma #(.AW(16), .DW(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .fill       (fill),
      .src        (src),
      .dst        (dst),
      .count      (count),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .mem        (m)
   );

   always #5 clk = ~clk;

   // Memory model: single-cycle registered read, read-before-write, bench preload port
   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] rd_q = '0;
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [15:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (m.mem_we) mem[m.mem_waddr] <= m.mem_wdata;
      if (m.mem_re) rd_q <= mem[m.mem_raddr];
   end
   assign m.mem_rdata = rd_q;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-command observation log
   int re_cnt, re_first, re_last, we_cnt, we_first, we_last;
   int done_cnt, done_cyc, busy_cnt, busy_first, busy_last, post_act;
   logic rst_re, rst_we, rst_busy, rst_done;
   logic [15:0] raddr_q[$], waddr_q[$], wdata_q[$];
   logic [15:0] exp_rq[$], exp_wq[$];

   task automatic preload(input logic [15:0] a, input logic [15:0] v);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = v;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic snapshot();
      for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];
   endtask

   // memmove semantics: result is as if the whole source were read first
   task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
      logic [15:0] tmp[$];
      for (int i = 0; i < n; i++) tmp.push_back(ref_mem[16'(s + i)]);
      for (int i = 0; i < n; i++) ref_mem[16'(d + i)] = tmp[i];
   endtask

   task automatic model_fill(input logic [15:0] d, input int n, input logic [15:0] v);
      for (int i = 0; i < n; i++) ref_mem[16'(d + i)] = v;
   endtask

   task automatic build_exp(input logic f, input logic [15:0] s, input logic [15:0] d, input int n);
      int off;
      exp_rq.delete(); exp_wq.delete();
      for (int i = 0; i < n; i++) begin
         off = (!f && d > s) ? (n - 1 - i) : i;
         if (!f) exp_rq.push_back(16'(s + off));
         exp_wq.push_back(16'(d + off));
      end
   endtask

   function automatic int mem_diffs();
      int b = 0;
      for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) b++;
      return b;
   endfunction

   function automatic int seq_diffs(input logic [15:0] got[$], input logic [15:0] exp[$]);
      int b = 0;
      if (got.size() != exp.size()) return 1000 + got.size();
      foreach (got[i]) if (got[i] !== exp[i]) b++;
      return b;
   endfunction

   // Issue one command and log per-cycle strobes; cycle k is sampled at the negedge after E0+k-1
   task automatic run_cmd(input logic f, input logic [15:0] s, input logic [15:0] d,
                          input int n, input logic [15:0] fv, input int poke_cyc, input int rst_cyc);
      re_cnt = 0; re_first = 0; re_last = 0; we_cnt = 0; we_first = 0; we_last = 0;
      done_cnt = 0; done_cyc = 0; busy_cnt = 0; busy_first = 0; busy_last = 0; post_act = 0;
      rst_re = 1'b1; rst_we = 1'b1; rst_busy = 1'b1; rst_done = 1'b1;
      raddr_q.delete(); waddr_q.delete(); wdata_q.delete();
      @(negedge clk);
      start = 1'b1; fill = f; src = s; dst = d; count = 16'(n); fill_value = fv;
      for (int k = 1; k <= n + 8; k++) begin
         @(negedge clk);
         start = (k == poke_cyc);
         if (k == poke_cyc) begin
            dst = d ^ 16'h0F00; src = s + 16'd1; fill = ~f; count = 16'(n + 1);
         end
         if (m.mem_re) begin
            re_cnt++; if (re_first == 0) re_first = k; re_last = k; raddr_q.push_back(m.mem_raddr);
         end
         if (m.mem_we) begin
            we_cnt++; if (we_first == 0) we_first = k; we_last = k;
            waddr_q.push_back(m.mem_waddr); wdata_q.push_back(m.mem_wdata);
         end
         if (done) begin done_cnt++; done_cyc = k; end
         if (busy) begin busy_cnt++; if (busy_first == 0) busy_first = k; busy_last = k; end
         if (rst_cyc != 0 && k > rst_cyc && (m.mem_re || m.mem_we || done || busy)) post_act++;
         if (rst_cyc != 0 && k == rst_cyc) begin
            reset_n = 1'b0;
            #1;
            rst_re = m.mem_re; rst_we = m.mem_we; rst_busy = busy; rst_done = done;
         end
         if (rst_cyc != 0 && k == rst_cyc + 1) reset_n = 1'b1;
         if (done_cyc != 0 && k > done_cyc) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b exp=0", done); end
      n_cmp++; if (m.mem_re !== 1'b0) begin n_bad++; $display("FAIL reset_re got=%0b exp=0", m.mem_re); end
      n_cmp++; if (m.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%0b exp=0", m.mem_we); end
      n_cmp++; if (m.mem_raddr !== 16'h0) begin n_bad++; $display("FAIL reset_raddr got=%h exp=0", m.mem_raddr); end
      n_cmp++; if (m.mem_waddr !== 16'h0) begin n_bad++; $display("FAIL reset_waddr got=%h exp=0", m.mem_waddr); end
      n_cmp++; if (m.mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_wdata got=%h exp=0", m.mem_wdata); end
   endtask

   task automatic test_copy_asc();
      for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), 16'($urandom));
      snapshot(); model_copy(16'h0100, 16'h0200, 4); build_exp(1'b0, 16'h0100, 16'h0200, 4);
      run_cmd(1'b0, 16'h0100, 16'h0200, 4, 16'h0, 0, 0);
      n_cmp++; if (re_first !== 1 || re_cnt !== 4 || re_last !== 4) begin n_bad++;
         $display("FAIL asc_re first=%0d cnt=%0d last=%0d exp=1/4/4", re_first, re_cnt, re_last); end
      n_cmp++; if (we_first !== 2 || we_cnt !== 4 || we_last !== 5) begin n_bad++;
         $display("FAIL asc_we first=%0d cnt=%0d last=%0d exp=2/4/5", we_first, we_cnt, we_last); end
      n_cmp++; if (done_cyc !== 6 || done_cnt !== 1) begin n_bad++;
         $display("FAIL asc_done cyc=%0d cnt=%0d exp=6/1", done_cyc, done_cnt); end
      n_cmp++; if (busy_first !== 1 || busy_last !== 6 || busy_cnt !== 6) begin n_bad++;
         $display("FAIL asc_busy first=%0d last=%0d cnt=%0d exp=1/6/6", busy_first, busy_last, busy_cnt); end
      n_cmp++; if (seq_diffs(raddr_q, exp_rq) !== 0) begin n_bad++;
         $display("FAIL asc_raddr diffs=%0d exp=0", seq_diffs(raddr_q, exp_rq)); end
      n_cmp++; if (seq_diffs(waddr_q, exp_wq) !== 0) begin n_bad++;
         $display("FAIL asc_waddr diffs=%0d exp=0", seq_diffs(waddr_q, exp_wq)); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL asc_mem diffs=%0d exp=0", mem_diffs()); end
   endtask

   task automatic test_fill();
      logic [15:0] bee[$];
      bee = '{16'hBEEF, 16'hBEEF, 16'hBEEF};
      snapshot(); model_fill(16'h0010, 3, 16'hBEEF); build_exp(1'b1, 16'h0000, 16'h0010, 3);
      run_cmd(1'b1, 16'h0000, 16'h0010, 3, 16'hBEEF, 0, 0);
      n_cmp++; if (re_cnt !== 0) begin n_bad++; $display("FAIL fill_re cnt=%0d exp=0", re_cnt); end
      n_cmp++; if (we_first !== 1 || we_cnt !== 3 || we_last !== 3) begin n_bad++;
         $display("FAIL fill_we first=%0d cnt=%0d last=%0d exp=1/3/3", we_first, we_cnt, we_last); end
      n_cmp++; if (done_cyc !== 4 || done_cnt !== 1 || busy_cnt !== 4) begin n_bad++;
         $display("FAIL fill_done cyc=%0d cnt=%0d busy=%0d exp=4/1/4", done_cyc, done_cnt, busy_cnt); end
      n_cmp++; if (seq_diffs(waddr_q, exp_wq) !== 0) begin n_bad++;
         $display("FAIL fill_waddr diffs=%0d exp=0", seq_diffs(waddr_q, exp_wq)); end
      n_cmp++; if (seq_diffs(wdata_q, bee) !== 0) begin n_bad++;
         $display("FAIL fill_wdata diffs=%0d exp=0", seq_diffs(wdata_q, bee)); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL fill_mem diffs=%0d exp=0", mem_diffs()); end
   endtask

   task automatic test_overlap();
      logic [15:0] wexp[$];
      wexp = '{16'h0005, 16'h0004, 16'h0003, 16'h0002};
      for (int i = 0; i < 4; i++) preload(16'(i), 16'(i + 1));
      snapshot(); model_copy(16'h0000, 16'h0002, 4);
      run_cmd(1'b0, 16'h0000, 16'h0002, 4, 16'h0, 0, 0);
      n_cmp++; if (seq_diffs(waddr_q, wexp) !== 0) begin n_bad++;
         $display("FAIL ovl_order first_waddr=%h exp=0005 diffs=%0d", waddr_q.size() > 0 ? waddr_q[0] : 16'hxxxx,
                  seq_diffs(waddr_q, wexp)); end
      n_cmp++; if (mem[2] !== 16'd1 || mem[3] !== 16'd2 || mem[4] !== 16'd3 || mem[5] !== 16'd4) begin n_bad++;
         $display("FAIL ovl_data got=%h %h %h %h exp=1 2 3 4", mem[2], mem[3], mem[4], mem[5]); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL ovl_mem diffs=%0d exp=0", mem_diffs()); end
   endtask

   task automatic test_wrap_zero();
      logic [15:0] rexp[$];
      rexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      for (int i = 0; i < 4; i++) preload(16'hFFFE + 16'(i), 16'($urandom));
      snapshot(); model_copy(16'hFFFE, 16'h1000, 4);
      run_cmd(1'b0, 16'hFFFE, 16'h1000, 4, 16'h0, 0, 0);
      n_cmp++; if (seq_diffs(raddr_q, rexp) !== 0) begin n_bad++;
         $display("FAIL wrap_raddr diffs=%0d exp=0", seq_diffs(raddr_q, rexp)); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL wrap_mem diffs=%0d exp=0", mem_diffs()); end
      snapshot();
      run_cmd(1'b0, 16'h0123, 16'h0456, 0, 16'h0, 0, 0);
      n_cmp++; if (done_cyc !== 1 || done_cnt !== 1 || busy_cnt !== 1) begin n_bad++;
         $display("FAIL zero_done cyc=%0d cnt=%0d busy=%0d exp=1/1/1", done_cyc, done_cnt, busy_cnt); end
      n_cmp++; if (re_cnt !== 0 || we_cnt !== 0) begin n_bad++;
         $display("FAIL zero_strobes re=%0d we=%0d exp=0/0", re_cnt, we_cnt); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL zero_mem diffs=%0d exp=0", mem_diffs()); end
   endtask

   task automatic test_start_busy();
      for (int i = 0; i < 4; i++) preload(16'h0300 + 16'(i), 16'($urandom));
      snapshot(); model_copy(16'h0300, 16'h0400, 4); build_exp(1'b0, 16'h0300, 16'h0400, 4);
      run_cmd(1'b0, 16'h0300, 16'h0400, 4, 16'h0, 2, 0);
      n_cmp++; if (seq_diffs(waddr_q, exp_wq) !== 0) begin n_bad++;
         $display("FAIL busy_waddr diffs=%0d exp=0", seq_diffs(waddr_q, exp_wq)); end
      n_cmp++; if (done_cyc !== 6 || done_cnt !== 1 || busy_last !== 6) begin n_bad++;
         $display("FAIL busy_done cyc=%0d cnt=%0d busy_last=%0d exp=6/1/6", done_cyc, done_cnt, busy_last); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL busy_mem diffs=%0d exp=0", mem_diffs()); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) preload(16'h0700 + 16'(i), 16'($urandom));
      snapshot();
      ref_mem[16'h0600] = ref_mem[16'h0700];
      run_cmd(1'b0, 16'h0700, 16'h0600, 4, 16'h0, 0, 3);
      n_cmp++; if (rst_re !== 1'b0 || rst_we !== 1'b0 || rst_busy !== 1'b0 || rst_done !== 1'b0) begin n_bad++;
         $display("FAIL rst_outputs re=%0b we=%0b busy=%0b done=%0b exp=0/0/0/0", rst_re, rst_we, rst_busy, rst_done); end
      n_cmp++; if (done_cnt !== 0 || post_act !== 0) begin n_bad++;
         $display("FAIL rst_abandon done=%0d post_act=%0d exp=0/0", done_cnt, post_act); end
      n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL rst_mem diffs=%0d exp=0", mem_diffs()); end
      snapshot(); model_copy(16'h0700, 16'h0600, 4); build_exp(1'b0, 16'h0700, 16'h0600, 4);
      run_cmd(1'b0, 16'h0700, 16'h0600, 4, 16'h0, 0, 0);
      n_cmp++; if (done_cyc !== 6 || re_cnt !== 4 || we_first !== 2 || we_cnt !== 4) begin n_bad++;
         $display("FAIL rst_after done=%0d re=%0d wef=%0d we=%0d exp=6/4/2/4", done_cyc, re_cnt, we_first, we_cnt); end
      n_cmp++; if (mem_diffs() !== 0 || seq_diffs(waddr_q, exp_wq) !== 0) begin n_bad++;
         $display("FAIL rst_after_mem diffs=%0d exp=0", mem_diffs()); end
   endtask

   task automatic test_random();
      logic [15:0] s, d, fv;
      logic        f;
      int          n;
      for (int it = 0; it < 8; it++) begin
         f  = (it % 3 == 2);
         s  = 16'($urandom);
         d  = ($urandom_range(0, 1) == 1) ? s + 16'($urandom_range(0, 6)) - 16'd3 : 16'($urandom);
         n  = $urandom_range(1, 20);
         fv = 16'($urandom);
         if (!f) for (int i = 0; i < n; i++) preload(16'(s + i), 16'($urandom));
         snapshot();
         if (f) model_fill(d, n, fv); else model_copy(s, d, n);
         build_exp(f, s, d, n);
         run_cmd(f, s, d, n, fv, 0, 0);
         n_cmp++;
         if (re_cnt !== (f ? 0 : n) || we_cnt !== n || we_first !== (f ? 1 : 2) || done_cyc !== (f ? n + 1 : n + 2)
             || done_cnt !== 1 || busy_cnt !== done_cyc) begin n_bad++;
            $display("FAIL rnd%0d_timing f=%0b n=%0d re=%0d we=%0d wef=%0d done=%0d busy=%0d", it, f, n,
                     re_cnt, we_cnt, we_first, done_cyc, busy_cnt); end
         n_cmp++;
         if (seq_diffs(raddr_q, exp_rq) !== 0 || seq_diffs(waddr_q, exp_wq) !== 0) begin n_bad++;
            $display("FAIL rnd%0d_addr s=%h d=%h n=%0d rdiff=%0d wdiff=%0d exp=0/0", it, s, d, n,
                     seq_diffs(raddr_q, exp_rq), seq_diffs(waddr_q, exp_wq)); end
         n_cmp++;
         if (mem_diffs() !== 0) begin n_bad++;
            $display("FAIL rnd%0d_mem s=%h d=%h n=%0d diffs=%0d exp=0", it, s, d, n, mem_diffs()); end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_copy_asc();
      test_fill();
      test_overlap();
      test_wrap_zero();
      test_start_busy();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
